// File: rtl/frame_sched.sv
// Per-frame update sequencer: on each accepted vblnk rising edge, start the enabled requesters one at a time in
// ascending order, with a watchdog per requester and sticky status flags.
module frame_sched #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic [3:0]  en,
    input  logic [3:0]  upd_done,
    input  logic        clr_flags,
    output logic [3:0]  upd_start,
    output logic        frame_tick,
    output logic        busy,
    output logic [3:0]  overrun,
    output logic        late,
    output logic [15:0] frame_cnt,
    output logic [7:0]  skip_cnt
);

    localparam int unsigned WD_W = 13;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      mask_q, mask_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            vblnk_q;

    logic [3:0]      upd_start_d, overrun_d;
    logic            frame_tick_d, busy_d, late_d;
    logic [15:0]     frame_cnt_d;
    logic [7:0]      skip_cnt_d;

    logic            rise, fall, adv;
    logic            nxt_found;
    logic [1:0]      nxt_idx, low_idx;

    assign rise = vblnk & ~vblnk_q;
    assign fall = ~vblnk & vblnk_q;

    // Lowest enabled requester and next higher mask bit above the current index
    always_comb begin
        low_idx   = 2'd0;
        nxt_found = 1'b0;
        nxt_idx   = idx_q;
        for (int i = 3; i >= 0; i--) begin
            if (en[i]) low_idx = 2'(i);
            if (mask_q[i] && (i > int'(idx_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = 2'(i);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        wdog_d       = wdog_q;
        adv          = 1'b0;
        upd_start_d  = '0;
        frame_tick_d = rise;
        frame_cnt_d  = rise ? frame_cnt + 16'd1 : frame_cnt;
        overrun_d    = clr_flags ? 4'd0 : overrun;
        late_d       = clr_flags ? 1'b0 : late;
        skip_cnt_d   = clr_flags ? 8'd0 : skip_cnt;

        if (fall && busy) late_d = 1'b1;
        if (rise && busy) skip_cnt_d = (skip_cnt == 8'hFF) ? 8'hFF : skip_cnt + 8'd1;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    mask_d = en;
                    if (en != 4'd0) begin
                        idx_d   = low_idx;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (upd_done[idx_q]) begin
                    adv = 1'b1;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    adv                = 1'b1;
                    overrun_d[idx_q]   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (nxt_found) begin
                idx_d   = nxt_idx;
                state_d = ISSUE;
            end else begin
                state_d = IDLE;
            end
        end

        busy_d = (state_d != IDLE);
        // Start pulse is visible during the ISSUE cycle itself
        if (state_d == ISSUE) upd_start_d = 4'd1 << idx_d;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            mask_q     <= 4'd0;
            wdog_q     <= '0;
            vblnk_q    <= 1'b1;
            upd_start  <= 4'd0;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 4'd0;
            late       <= 1'b0;
            frame_cnt  <= 16'd0;
            skip_cnt   <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            wdog_q     <= wdog_d;
            vblnk_q    <= vblnk;
            upd_start  <= upd_start_d;
            frame_tick <= frame_tick_d;
            busy       <= busy_d;
            overrun    <= overrun_d;
            late       <= late_d;
            frame_cnt  <= frame_cnt_d;
            skip_cnt   <= skip_cnt_d;
        end
    end

endmodule
